// File: rtl/smg_pkg.sv
// rtl/smg_pkg.sv - shared constants, segment code table and state encoding for smg_decoder
package smg_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int NUM_CODES  = 10;
    localparam logic [3:0] ERR_NIBBLE = 4'hF;

    // Active-low segment codes for digits 0..9, dp bit shown high.
    localparam logic [7:0] SEG_CODE [NUM_CODES] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    function automatic logic one_low(input logic [NUM_DIGITS-1:0] scan);
        logic [NUM_DIGITS-1:0] inv;
        inv = ~scan;
        return (inv != '0) && ((inv & (inv - 1'b1)) == '0);
    endfunction

    function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] scan);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!scan[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - maps active-low g..a segment bits to a BCD nibble plus valid flag
module seg7_decode
    import smg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       valid
);

    always_comb begin
        nibble = ERR_NIBBLE;
        valid  = 1'b0;
        for (int i = 0; i < NUM_CODES; i++) begin
            if (seg == SEG_CODE[i][6:0]) begin
                nibble = 4'(i);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smg_decoder.sv
// rtl/smg_decoder.sv - recovers a 6-digit BCD value by sniffing a multiplexed 7-segment display
module smg_decoder
    import smg_pkg::*;
#(
    parameter int SETTLE     = 4,
    parameter int TIMEOUT_MS = 10
) (
    input  logic                    clk_sys,
    input  logic                    rst_n,
    input  logic                    pluse_ms,
    input  logic [NUM_DIGITS-1:0]   smg_scan,
    input  logic [7:0]              smg_data,
    output logic [4*NUM_DIGITS-1:0] number_out,
    output logic                    frame_vld,
    output logic                    seg_err,
    output logic                    stale
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [9:0] MS_LAST     = 10'(TIMEOUT_MS - 1);
    localparam logic [9:0] MS_TOP      = 10'(TIMEOUT_MS);

    logic [NUM_DIGITS-1:0]      scan_q, scan_prev, mask, new_mask;
    logic [7:0]                 data_q, data_prev, settle_cnt;
    logic [9:0]                 ms_cnt;
    logic [NUM_DIGITS-1:0][3:0] shadow, shadow_upd;
    state_t                     state, state_nxt;
    logic                       scan_chg, data_chg, scan_ok, cnt_clr, capture;
    logic [2:0]                 cap_idx;
    logic [3:0]                 dec_nib;
    logic                       dec_ok;

    assign scan_chg = (scan_q != scan_prev);
    assign data_chg = (data_q != data_prev);
    assign scan_ok  = one_low(scan_q);
    assign capture  = (state == ST_CAPTURE);

    // During CAPTURE the *_prev copies still hold the values that were counted
    // stable; the *_q copies may already show the next port value.
    assign cap_idx = low_index(scan_prev);

    seg7_decode u_dec (
        .seg    (data_prev[6:0]),
        .nibble (dec_nib),
        .valid  (dec_ok)
    );

    always_comb begin
        shadow_upd          = shadow;
        shadow_upd[cap_idx] = dec_nib;
        new_mask            = mask | (NUM_DIGITS'(1) << cap_idx);
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        case (state)
            ST_SETTLE: begin
                if (scan_chg && !scan_ok) begin
                    state_nxt = ST_IDLE;
                end else if (scan_chg || data_chg) begin
                    cnt_clr = 1'b1;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                if (scan_chg && scan_ok) begin
                    state_nxt = ST_SETTLE;
                    cnt_clr   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            scan_q     <= '1;
            scan_prev  <= '1;
            data_q     <= '1;
            data_prev  <= '1;
            state      <= ST_IDLE;
            settle_cnt <= '0;
        end else begin
            scan_q    <= smg_scan;
            scan_prev <= scan_q;
            data_q    <= smg_data;
            data_prev <= data_q;
            state     <= state_nxt;
            if (cnt_clr) begin
                settle_cnt <= '0;
            end else if (state == ST_SETTLE && settle_cnt != 8'hFF) begin
                settle_cnt <= settle_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            mask       <= '0;
            number_out <= '0;
            frame_vld  <= 1'b0;
            seg_err    <= 1'b0;
            ms_cnt     <= '0;
            stale      <= 1'b0;
        end else begin
            frame_vld <= 1'b0;
            seg_err   <= 1'b0;
            if (capture) begin
                shadow  <= shadow_upd;
                seg_err <= !dec_ok;
                ms_cnt  <= '0;
                stale   <= 1'b0;
                if (new_mask == '1) begin
                    number_out <= shadow_upd;
                    frame_vld  <= 1'b1;
                    mask       <= '0;
                end else begin
                    mask <= new_mask;
                end
            end else if (pluse_ms && ms_cnt != MS_TOP) begin
                ms_cnt <= ms_cnt + 10'd1;
                if (ms_cnt == MS_LAST) begin
                    stale <= 1'b1;
                    mask  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_smg_decoder.sv
// tb/tb_smg_decoder.sv - randomized scoreboard bench for smg_decoder
module tb_smg_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 10;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        pluse_ms = 1'b0;
    logic [5:0]  smg_scan = 6'h3F;
    logic [7:0]  smg_data = 8'hFF;
    logic [23:0] number_out;
    logic        frame_vld, seg_err, stale;

    always #5 clk_sys = ~clk_sys;

    smg_decoder #(.SETTLE(SETTLE), .TIMEOUT_MS(TIMEOUT)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .pluse_ms   (pluse_ms),
        .smg_scan   (smg_scan),
        .smg_data   (smg_data),
        .number_out (number_out),
        .frame_vld  (frame_vld),
        .seg_err    (seg_err),
        .stale      (stale)
    );

    typedef struct {
        logic [23:0] val;
        int          cyc;
    } frame_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    frame_t q_frame[$];
    int q_err[$];

    logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'h80 ^ 8'h78 ^ 8'h80, 8'h80, 8'h90};
    logic [3:0] sh_m [6];
    logic [5:0] mask_m = '0;
    logic [23:0] num_m = '0;
    int ms_m = 0;
    bit stale_m = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [7:0] d);
        for (int i = 0; i < 10; i++) begin
            if (d[6:0] == codes[i][6:0]) return 4'(i);
        end
        return 4'hF;
    endfunction

    task automatic model_capture(input int k, input logic [7:0] d, input int out_cyc);
        frame_t f;
        sh_m[k] = ref_decode(d);
        if (sh_m[k] == 4'hF) q_err.push_back(out_cyc);
        mask_m[k] = 1'b1;
        ms_m = 0;
        stale_m = 1'b0;
        if (mask_m == 6'h3F) begin
            num_m = {sh_m[5], sh_m[4], sh_m[3], sh_m[2], sh_m[1], sh_m[0]};
            f.val = num_m;
            f.cyc = out_cyc;
            q_frame.push_back(f);
            mask_m = '0;
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Blank for two cycles, then show digit k; output is due SETTLE+3 cycles
    // after the last data change on the port.
    task automatic present(input int k, input logic [7:0] d, input int hold,
                           input bit glitch, input bit pulse_cap);
        int c, extra;
        smg_scan = 6'h3F;
        step();
        step();
        c = cyc;
        extra = glitch ? 2 : 0;
        smg_scan = ~(6'b1 << k);
        smg_data = d;
        model_capture(k, d, c + SETTLE + 3 + extra);
        for (int i = 1; i < hold; i++) begin
            step();
            smg_data = (glitch && i == 1) ? (d ^ 8'h5A) : d;
            pluse_ms = pulse_cap && (i == SETTLE + 2 + extra);
        end
        step();
        pluse_ms = 1'b0;
        check("number_out_hold", 32'(number_out), 32'(num_m));
        check("stale_after_capture", 32'(stale), 32'(stale_m));
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            pluse_ms = 1'b1;
            step();
            pluse_ms = 1'b0;
            step();
            if (ms_m < TIMEOUT) begin
                ms_m++;
                if (ms_m == TIMEOUT) begin
                    stale_m = 1'b1;
                    mask_m = '0;
                end
            end
        end
    endtask

    task automatic bad_scan();
        smg_scan = 6'b111100;
        smg_data = codes[3];
        for (int i = 0; i < 20; i++) step();
    endtask

    task automatic do_reset();
        smg_scan = 6'h3F;
        smg_data = 8'hFF;
        pluse_ms = 1'b0;
        rst_n = 1'b0;
        #3;
        check("rst_number_out", 32'(number_out), 32'h0);
        check("rst_frame_vld", 32'(frame_vld), 32'h0);
        check("rst_seg_err", 32'(seg_err), 32'h0);
        check("rst_stale", 32'(stale), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        mask_m = '0;
        num_m = '0;
        ms_m = 0;
        stale_m = 1'b0;
        step();
    endtask

    task automatic frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3, input logic [7:0] d4, input logic [7:0] d5);
        present(0, d0, 20, 1'b0, 1'b0);
        present(1, d1, 20, 1'b0, 1'b0);
        present(2, d2, 20, 1'b0, 1'b0);
        present(3, d3, 20, 1'b0, 1'b0);
        present(4, d4, 20, 1'b0, 1'b0);
        present(5, d5, 20, 1'b0, 1'b0);
    endtask

    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (frame_vld) begin
                if (q_frame.size() == 0) begin
                    check("unexpected_frame_vld", 32'(number_out), 32'hFFFFFFFF);
                end else begin
                    frame_t f;
                    f = q_frame.pop_front();
                    check("frame_value", 32'(number_out), 32'(f.val));
                    check("frame_cycle", 32'(cyc), 32'(f.cyc));
                end
            end
            if (seg_err) begin
                if (q_err.size() == 0) begin
                    check("unexpected_seg_err", 32'(cyc), 32'hFFFFFFFF);
                end else begin
                    check("seg_err_cycle", 32'(cyc), 32'(q_err.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, hold;
        logic [7:0] d;
        bit gl;

        step();
        do_reset();

        // Digit order 0..5 showing 3,2,1,0,0,0
        frame(codes[3], codes[2], codes[1], codes[0], codes[0], codes[0]);
        check("frame_000123", 32'(number_out), 32'h000123);

        // Blank digit 2
        frame(codes[4], codes[5], 8'hFF, codes[7], codes[8], codes[9]);
        check("frame_blank_digit", 32'(number_out), 32'h987F54);

        // Data glitches, including on the frame-completing digit
        present(0, codes[6], 20, 1'b0, 1'b0);
        present(1, codes[1], 20, 1'b0, 1'b0);
        present(2, codes[2], 20, 1'b0, 1'b0);
        present(3, codes[9], 20, 1'b1, 1'b0);
        present(4, codes[4], 20, 1'b0, 1'b0);
        present(5, codes[7], 20, 1'b1, 1'b0);

        // Two low scan bits mid-frame
        present(0, codes[1], 20, 1'b0, 1'b0);
        present(1, codes[2], 20, 1'b0, 1'b0);
        present(2, codes[3], 20, 1'b0, 1'b0);
        bad_scan();
        present(3, codes[4], 20, 1'b0, 1'b0);
        present(4, codes[5], 20, 1'b0, 1'b0);
        present(5, codes[6], 20, 1'b0, 1'b0);

        // Timeout discards a partial frame
        present(0, codes[8], 20, 1'b0, 1'b0);
        present(1, codes[8], 20, 1'b0, 1'b0);
        present(2, codes[8], 20, 1'b0, 1'b0);
        pulses(TIMEOUT - 1);
        check("stale_before_timeout", 32'(stale), 32'(stale_m));
        pulses(1);
        check("stale_at_timeout", 32'(stale), 32'(stale_m));
        pulses(3);
        check("stale_saturated", 32'(stale), 32'(stale_m));
        frame(codes[2], codes[4], codes[6], codes[8], codes[1], codes[3]);

        // Pulse coinciding with capture: capture wins
        present(0, codes[5], 20, 1'b0, 1'b1);
        pulses(TIMEOUT - 1);
        check("stale_after_coincide", 32'(stale), 32'(stale_m));
        pulses(1);
        check("stale_after_coincide_timeout", 32'(stale), 32'(stale_m));

        // Reset mid-frame
        present(0, codes[7], 20, 1'b0, 1'b0);
        present(1, codes[7], 20, 1'b0, 1'b0);
        present(2, codes[7], 20, 1'b0, 1'b0);
        do_reset();
        frame(codes[9], codes[8], codes[7], codes[6], codes[5], codes[4]);
        check("frame_after_reset", 32'(number_out), 32'h456789);

        // Randomized digit traffic with repeats, bad codes, dp noise and glitches
        for (int n = 0; n < 150; n++) begin
            k = int'($urandom_range(0, 5));
            if ($urandom_range(0, 9) < 8) begin
                d = codes[$urandom_range(0, 9)];
                d[7] = 1'($urandom_range(0, 1));
            end else begin
                d = 8'($urandom);
            end
            gl = ($urandom_range(0, 5) == 0);
            hold = int'($urandom_range(12, 24));
            present(k, d, hold, gl, 1'b0);
            if ($urandom_range(0, 19) == 0) bad_scan();
        end

        for (int i = 0; i < 30; i++) step();
        check("pending_frames", 32'(q_frame.size()), 32'h0);
        check("pending_seg_err", 32'(q_err.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smg_decoder.md
SMG_DECODER -- requirements
Module: smg_decoder

Interface
REQ-001 SETTLE, default 4: clk_sys cycles a new scan value must hold stable before its digit is captured; range 1..255.
REQ-002 TIMEOUT_MS, default 10: pluse_ms pulses without a capture before stale asserts; range 1..1023.
REQ-003 clk_sys  in  1  system clock; sole clock domain.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 pluse_ms  in  1  one-cycle 1 ms tick, synchronous to clk_sys.
REQ-006 smg_scan  in  6  digit select; active-low one-hot; bit0 = least significant digit.
REQ-007 smg_data  in  8  segment drive; active-low; bit7 = dp (ignored), bits6:0 = g..a.
REQ-008 number_out  out  24  recovered BCD value; nibble k = digit k.
REQ-009 frame_vld  out  1  one-cycle pulse when number_out updates.
REQ-010 seg_err  out  1  one-cycle pulse when a captured pattern is not a valid digit.
REQ-011 stale  out  1  level; no capture within TIMEOUT_MS.

Function
REQ-012 smg_scan and smg_data shall be registered once before any use; all decisions use the registered copies.
REQ-013 States shall be IDLE, SETTLE and CAPTURE.
REQ-014 IDLE -> SETTLE shall occur when the registered scan differs from its previous value and has exactly one low bit; the settle counter clears.
REQ-015 A scan change to a value with zero or several low bits shall force IDLE with no capture.
REQ-016 In SETTLE, any scan or data change shall restart the count; after SETTLE stable cycles the state shall go to CAPTURE.
REQ-017 CAPTURE shall last one cycle, store the decoded nibble into shadow[k] for the low scan bit k, set mask bit k, then return to IDLE.
REQ-018 Decode shall follow the package table: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex, data[6:0] with dp masked high).
REQ-019 Any other pattern shall store 4'hF and pulse seg_err in the cycle after CAPTURE.
REQ-020 A digit captured again before the frame completes shall overwrite its nibble; the mask is unchanged.
REQ-021 When a capture makes mask = 6'h3F, the module shall load number_out from shadow, including the new nibble, pulse frame_vld in the same cycle, and clear the mask.
REQ-022 frame_vld shall assert exactly SETTLE+3 clk_sys cycles after the final digit's scan value first appears on the port, with data held stable.
REQ-023 number_out shall hold its value between frames.
REQ-024 The ms counter shall clear on every CAPTURE and increment on each pluse_ms.
REQ-025 On reaching TIMEOUT_MS, stale shall set, the mask shall clear (the partial frame is discarded), and the counter shall saturate.
REQ-026 stale shall clear on the next CAPTURE.
REQ-027 If pluse_ms and CAPTURE coincide, CAPTURE shall win: the counter goes to 0 and stale does not set.

Reset
REQ-028 Reset shall set number_out=0, frame_vld=0, seg_err=0, stale=0, mask=0, ms counter=0, settle counter=0, state IDLE, and input registers to all-ones (inactive).
REQ-029 Reset mid-frame shall discard all captured digits; the first frame after reset requires six fresh captures.

Structure
REQ-030 Package smg_pkg shall hold the digit count (6), the segment code table, the error nibble (4'hF) and the state encoding.
REQ-031 Combinational sub-module seg7_decode shall map 7 segment bits to a 4-bit nibble plus a valid flag.
REQ-032 All sequential logic shall stay in smg_decoder.

Verification
REQ-033 Scan digits 0..5 with codes for 3,2,1,0,0,0 (digit0 first), each held 20 cycles -> one frame_vld, number_out = 24'h000123.
REQ-034 Digit2 data = 8'hFF (blank) in an otherwise valid frame -> seg_err pulses once; number_out nibble2 = F.
REQ-035 Data glitches 1 cycle after a scan edge, SETTLE=4 -> capture delayed to 4 stable cycles after the glitch; the correct digit is stored.
REQ-036 smg_scan = 6'b111100 (two low bits) mid-frame -> no capture, mask unchanged, no seg_err.
REQ-037 Scan frozen for 10 pluse_ms -> stale=1 and the partial frame is discarded; the next six captures produce frame_vld and stale=0 from the first capture.
REQ-038 rst_n low after 3 digits are captured, then a full frame -> exactly one frame_vld, issued only after all six post-reset captures.
